// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Purpose  : Three-stage pipelined floating-point multiplier for IEEE-754
//            style operands {sign, exponent, mantissa}. Rounds to nearest,
//            ties to even. Denormal inputs are flushed to zero and tiny
//            results are flushed to signed zero. Any NaN becomes the
//            canonical quiet NaN.
//
//            Stage 1 : unpack fields, classify zero / Inf / NaN
//            Stage 2 : full-width mantissa multiply, biased exponent sum
//            Stage 3 : normalise, round, range-check, pack
//
// Ports    : clk        - clock, every register updates on the rising edge
//            rst        - asynchronous active-high reset
//            data_iA    - operand A {sign, exp, mant}
//            data_iB    - operand B {sign, exp, mant}
//            Valid_In   - operand pair is valid this cycle
//            Ready_In   - pipeline accepts an operand pair this cycle
//            data_o     - product
//            Valid_Out  - data_o / flags_o hold a result
//            Ready_Out  - downstream takes the result this cycle
//            flags_o    - {invalid, overflow, underflow, inexact}
//
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int BUS_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] data_iA,
  input  logic [BUS_WIDTH-1:0] data_iB,
  input  logic                 Valid_In,
  output logic                 Ready_In,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 Valid_Out,
  input  logic                 Ready_Out,
  output logic [3:0]           flags_o
);

  // Product width of two (MAN_W+1)-bit significands, and the width of the
  // signed exponent arithmetic (two guard bits catch overflow and negatives).
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int FW = 1 + EXP_W + MAN_W;

  localparam logic signed [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Global flow control: the whole pipe moves together. It may move whenever
  // the output register is empty or is being drained this cycle, so a stall
  // freezes every stage and nothing in flight is lost or duplicated.
  // --------------------------------------------------------------------------
  logic advance;

  assign advance  = Ready_Out | ~Valid_Out;
  assign Ready_In = advance;

  // --------------------------------------------------------------------------
  // Stage 1: unpack and classify
  // --------------------------------------------------------------------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero;
  logic             a_inf, b_inf;
  logic             a_nan, b_nan;

  assign a_sign = data_iA[EXP_W+MAN_W];
  assign b_sign = data_iB[EXP_W+MAN_W];
  assign a_exp  = data_iA[MAN_W +: EXP_W];
  assign b_exp  = data_iB[MAN_W +: EXP_W];
  assign a_man  = data_iA[MAN_W-1:0];
  assign b_man  = data_iB[MAN_W-1:0];

  // A zero exponent is zero regardless of mantissa (denormals flush).
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_man == '0);
  assign b_inf  = (b_exp == '1) && (b_man == '0);
  assign a_nan  = (a_exp == '1) && (a_man != '0);
  assign b_nan  = (b_exp == '1) && (b_man != '0);

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;
  logic             s1_nan, s1_inf, s1_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_ea    <= '0;
      s1_eb    <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (advance) begin
      s1_valid <= Valid_In;
      s1_sign  <= a_sign ^ b_sign;
      s1_ea    <= a_exp;
      s1_eb    <= b_exp;
      s1_ma    <= {1'b1, a_man};
      s1_mb    <= {1'b1, b_man};
      // Inf x 0 is invalid just like a NaN operand; the remaining special
      // classes are resolved by priority in stage 3.
      s1_nan   <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      s1_inf   <= a_inf | b_inf;
      s1_zero  <= a_zero | b_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: significand multiply and exponent sum
  // --------------------------------------------------------------------------
  logic [PW-1:0]        prod;
  logic signed [EW-1:0] esum;

  assign prod = PW'(s1_ma) * PW'(s1_mb);
  assign esum = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;

  logic                 s2_valid;
  logic                 s2_sign;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_esum;
  logic                 s2_nan, s2_inf, s2_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_prod  <= '0;
      s2_esum  <= '0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_prod  <= prod;
      s2_esum  <= esum;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_zero  <= s1_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: normalise, round, range-check, pack
  // --------------------------------------------------------------------------
  // The product of two values in [1,2) lies in [1,4). When the top bit is
  // clear, shift left once so the hidden bit always sits at PW-1 and the
  // mantissa / guard / round / sticky positions are fixed.
  logic                 top;
  logic [PW-1:0]        norm;
  logic [MAN_W-1:0]     mant_t;
  logic                 guard, rnd, sticky;
  logic                 round_up;
  logic [MAN_W:0]       mant_sum;
  logic                 carry;
  logic [MAN_W-1:0]     mant_fin;
  logic signed [EW-1:0] exp_fin;
  logic                 inexact;
  logic                 unused_hidden;

  assign top           = s2_prod[PW-1];
  assign norm          = top ? s2_prod : (s2_prod << 1);
  assign unused_hidden = norm[PW-1];
  assign mant_t        = norm[PW-2 -: MAN_W];
  assign guard         = norm[PW-2-MAN_W];
  assign rnd           = norm[PW-3-MAN_W];
  assign sticky        = |norm[PW-4-MAN_W:0];

  // Nearest-even: round up above the halfway point, or exactly at it when
  // the kept LSB is odd.
  assign round_up = guard & (rnd | sticky | mant_t[0]);
  assign mant_sum = {1'b0, mant_t} + (MAN_W+1)'(round_up);

  // A carry out of the mantissa means the rounded value reached 2.0: bump
  // the exponent and the stored mantissa becomes all zeros.
  assign carry    = mant_sum[MAN_W];
  assign mant_fin = carry ? '0 : mant_sum[MAN_W-1:0];
  assign exp_fin  = s2_esum + $signed({{(EW-1){1'b0}}, top})
                            + $signed({{(EW-1){1'b0}}, carry});
  assign inexact  = guard | rnd | sticky;

  logic [FW-1:0] res;
  logic [3:0]    res_flags;

  always_comb begin
    res       = '0;
    res_flags = 4'b0000;
    if (s2_nan) begin
      res       = QNAN;
      res_flags = 4'b1000;
    end else if (s2_inf) begin
      res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_fin >= EXP_MAX) begin
      res       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else if (exp_fin <= $signed(EW'(0))) begin
      res       = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      res_flags = 4'b0011;
    end else begin
      res       = {s2_sign, exp_fin[EXP_W-1:0], mant_fin};
      res_flags = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Valid_Out <= 1'b0;
      data_o    <= '0;
      flags_o   <= 4'b0000;
    end else if (advance) begin
      Valid_Out <= s2_valid;
      // Bubbles leave the last payload untouched; only Valid_Out drops.
      if (s2_valid) begin
        data_o  <= BUS_WIDTH'(res);
        flags_o <= res_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_pipe
// Purpose  : Self-checking bench for fp_mul_pipe (default 32-bit format).
//            Directed vectors carry constant expected results; random
//            vectors are scored by an integer reference model that rounds
//            with quotient/remainder arithmetic. A scoreboard queue tracks
//            every accepted operation, its expected result and the number
//            of advancing clock edges at which it must appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] data_iA;
  logic [31:0] data_iB;
  logic        Valid_In;
  logic        Ready_In;
  logic [31:0] data_o;
  logic        Valid_Out;
  logic        Ready_Out;
  logic [3:0]  flags_o;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .BUS_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_iA   (data_iA),
    .data_iB   (data_iB),
    .Valid_In  (Valid_In),
    .Ready_In  (Ready_In),
    .data_o    (data_o),
    .Valid_Out (Valid_Out),
    .Ready_Out (Ready_Out),
    .flags_o   (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          adv;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  int          adv_cnt = 0;
  int          delivered = 0;
  int          stalled = 0;
  logic        last_acc;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [3:0]  prev_f;
  logic [35:0] cur_exp;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {flags, result}, flags = {invalid, overflow, underflow, inexact}
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inx;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf)  return {4'b0000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {4'b0000, s, 31'h0};
    ma = 64'h800000 + 64'(a[22:0]);
    mb = 64'h800000 + 64'(b[22:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, inx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       rand_op = r;
      1:       rand_op = {r[31], 8'hFF, (r[0] ? r[22:0] : 23'h0)};
      2:       rand_op = {r[31], 8'h00, r[22:0]};
      3:       rand_op = {r[31], 8'(($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : $urandom_range(230, 254)), r[22:0]};
      default: rand_op = {r[31], 8'($urandom_range(80, 175)), r[22:0]};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp);
    Valid_In = v;
    data_iA  = a;
    data_iB  = b;
    cur_exp  = exp;
  endtask

  // One clock: sample before the edge, score the output, log acceptance.
  task automatic cycle();
    logic ri, vo;
    logic [31:0] d;
    logic [3:0] f;
    entry_t e;
    #4;
    ri = Ready_In;
    vo = Valid_Out;
    d  = data_o;
    f  = flags_o;
    check32("ready_in", {31'b0, ri}, {31'b0, Ready_Out | ~vo});
    if (!ri) stalled++;
    if (vo) begin
      if (sb.size() == 0) begin
        check32("unexpected_output", d, 32'hxxxxxxxx);
      end else begin
        check32("data", d, sb[0].res);
        check32("flags", {28'b0, f}, {28'b0, sb[0].fl});
        check32("latency", adv_cnt, sb[0].adv + 2);
      end
      if (prev_stall) begin
        check32("stall_data", d, prev_d);
        check32("stall_flags", {28'b0, f}, {28'b0, prev_f});
      end
    end else if (sb.size() > 0 && sb[0].adv + 2 <= adv_cnt) begin
      check32("missing_output", {31'b0, vo}, 32'd1);
      void'(sb.pop_front());
    end
    prev_stall = vo && !Ready_Out;
    prev_d = d;
    prev_f = f;
    if (vo && Ready_Out && sb.size() > 0) begin
      void'(sb.pop_front());
      delivered++;
    end
    last_acc = Valid_In && ri && !rst;
    if (last_acc) begin
      e.res = cur_exp[31:0];
      e.fl  = cur_exp[35:32];
      e.adv = adv_cnt + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    if (ri) adv_cnt++;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ops_a[5];
    logic [31:0] ops_b[5];
    int idx, k, d0;
    rst = 1'b1;
    Ready_Out = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 36'h0);
    #1;
    check32("rst_valid_out", {31'b0, Valid_Out}, 32'd0);
    check32("rst_data", data_o, 32'h0);
    check32("rst_flags", {28'b0, flags_o}, 32'h0);
    check32("rst_ready_in", {31'b0, Ready_In}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back basic products; first op accepted on first edge after reset.
    drive(1'b1, 32'h40000000, 32'h40400000, {4'b0000, 32'h40C00000}); cycle();
    drive(1'b1, 32'h3FC00000, 32'h3FC00000, {4'b0000, 32'h40100000}); cycle();
    // Rounding, specials, range.
    drive(1'b1, 32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002}); cycle();
    drive(1'b1, 32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000}); cycle();
    drive(1'b1, 32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000}); cycle();
    drive(1'b1, 32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000}); cycle();
    drive(1'b1, 32'h7F7FFFFF, 32'h40000000, {4'b0101, 32'h7F800000}); cycle();
    drive(1'b1, 32'h00800000, 32'h00800000, {4'b0011, 32'h00000000}); cycle();
    drive(1'b1, 32'h00000001, 32'h3F800000, {4'b0000, 32'h00000000}); cycle();
    drive(1'b1, 32'h7FC12345, 32'h3F800000, {4'b1000, 32'h7FC00000}); cycle();
    drive(1'b0, 32'h0, 32'h0, 36'h0);
    repeat (5) cycle();
    check32("directed_drain", sb.size(), 0);

    // Backpressure: 5 ops, Ready_Out low for 4 cycles mid-stream.
    for (int i = 0; i < 5; i++) begin
      ops_a[i] = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      ops_b[i] = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    idx = 0;
    d0 = delivered;
    stalled = 0;
    for (k = 0; k < 40 && (idx < 5 || sb.size() > 0); k++) begin
      Ready_Out = !(k >= 3 && k < 7);
      if (idx < 5) drive(1'b1, ops_a[idx], ops_b[idx], model(ops_a[idx], ops_b[idx]));
      else drive(1'b0, 32'h0, 32'h0, 36'h0);
      cycle();
      if (last_acc) idx++;
    end
    Ready_Out = 1'b1;
    check32("bp_accepted", idx, 5);
    check32("bp_delivered", delivered - d0, 5);
    check32("bp_stall_cycles", stalled, 4);

    // Reset mid-operation.
    drive(1'b1, 32'h40000000, 32'h40000000, {4'b0000, 32'h40800000}); cycle();
    drive(1'b1, 32'h40400000, 32'h40400000, {4'b0000, 32'h41100000}); cycle();
    drive(1'b0, 32'h0, 32'h0, 36'h0);
    rst = 1'b1;
    #1;
    check32("midrst_valid_out", {31'b0, Valid_Out}, 32'd0);
    check32("midrst_data", data_o, 32'h0);
    check32("midrst_ready_in", {31'b0, Ready_In}, 32'd1);
    sb.delete();
    prev_stall = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (5) cycle();
    drive(1'b1, 32'h40A00000, 32'h40000000, {4'b0000, 32'h41200000}); cycle();
    drive(1'b0, 32'h0, 32'h0, 36'h0);
    repeat (4) cycle();
    check32("post_reset_drain", sb.size(), 0);

    // Random traffic with random backpressure, scored by the model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = rand_op();
      b = rand_op();
      Ready_Out = ($urandom_range(0, 9) < 7);
      drive(($urandom_range(0, 3) != 0), a, b, model(a, b));
      cycle();
    end
    Ready_Out = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 36'h0);
    repeat (6) cycle();
    check32("final_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: stored mantissa field width.
REQ-003 SHALL have parameter BUS_WIDTH, default 1+EXP_W+MAN_W (32): operand and result width.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have ports data_iA and data_iB, input, BUS_WIDTH: IEEE-754 style operands {sign, exp, mant}.
REQ-007 SHALL have port Valid_In, input, 1: operands valid this cycle.
REQ-008 SHALL have port Ready_In, output, 1: block accepts operands this cycle.
REQ-009 SHALL have port data_o, output, BUS_WIDTH: product.
REQ-010 SHALL have port Valid_Out, output, 1: data_o and flags_o valid.
REQ-011 SHALL have port Ready_Out, input, 1: downstream accepts the result.
REQ-012 SHALL have port flags_o, output, 4: {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL form a 3-stage pipeline: S1 unpack/classify, S2 mantissa multiply, S3 normalise/round/pack; each stage has its own valid bit.
REQ-014 SHALL use one global advance = Ready_Out | ~Valid_Out; all stages load only when advance = 1.
REQ-015 SHALL drive Ready_In = advance, combinationally.
REQ-016 SHALL accept an operand pair when Valid_In & Ready_In, and present its result on Valid_Out exactly 3 advancing cycles later (latency 3 with no stall, throughput 1/cycle).
REQ-017 SHALL hold data_o, flags_o and Valid_Out stable while Valid_Out = 1 and Ready_Out = 0, with no loss or duplication of any in-flight operation.
REQ-018 SHALL let bubbles (stage valid = 0) propagate, with Valid_Out = 0 for a bubble.
REQ-019 SHALL set result sign = sign A XOR sign B in all cases, including zero, Inf and NaN before canonicalisation.
REQ-020 SHALL treat exp = 0 as zero: mantissa is ignored and denormal inputs are flushed to zero.
REQ-021 SHALL treat exp = all-ones with mant != 0 as NaN, and exp = all-ones with mant = 0 as Inf.
REQ-022 SHALL apply special-case priority: any NaN, or Inf x zero -> canonical qNaN {0, all-ones, 1 followed by zeros} with invalid = 1; else any Inf -> signed Inf; else any zero -> signed zero; all other flags 0.
REQ-023 SHALL compute the normal-case exponent in EXP_W+2-bit signed arithmetic: eA + eB - bias, bias = 2^(EXP_W-1)-1, with +1 when the product's top bit (bit 2*MAN_W+1) is set.
REQ-024 SHALL multiply the {1,mant} operands (MAN_W+1 bits each) to give a full 2*MAN_W+2-bit product.
REQ-025 SHALL round to nearest, ties to even, using guard, round and sticky bits; inexact = 1 when any discarded bit is nonzero.
REQ-026 SHALL renormalise when rounding carries out of the mantissa: increment the exponent and zero the mantissa.
REQ-027 SHALL signal overflow when the final exponent >= all-ones: result = signed Inf, overflow = 1, inexact = 1.
REQ-028 SHALL signal underflow when the final exponent <= 0: result = signed zero (flush), underflow = 1, inexact = 1.

Reset
REQ-029 SHALL, while rst = 1, asynchronously clear all stage valid bits, data_o = 0, flags_o = 0 and Valid_Out = 0.
REQ-030 SHALL discard in-flight operations on reset mid-operation and produce no result for them after release.
REQ-031 SHALL hold Ready_In = 1 during reset and accept operands from the first clock edge after rst falls.

Verification
REQ-032 Basic and throughput: A=0x40000000, B=0x40400000 then A=B=0x3FC00000 on back-to-back cycles, Ready_Out=1 -> 0x40C00000 at cycle 3, then 0x40100000 at cycle 4, flags 0.
REQ-033 Rounding: A=B=0x3F800001 -> 0x3F800002, inexact=1.
REQ-034 Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0xFF800000 x 0x40000000 -> 0xFF800000; 0x80000000 x 0x3F800000 -> 0x80000000.
REQ-035 Range: 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1; denormal 0x00000001 x 0x3F800000 -> 0x00000000.
REQ-036 Backpressure: stream 5 products, hold Ready_Out=0 for 4 cycles mid-stream -> Ready_In=0 while stalled, data_o stable, all 5 results delivered in order exactly once.
REQ-037 Reset mid-operation: issue 2 ops, assert rst on the next cycle -> Valid_Out=0 immediately, no stale result after release, and a new op returns its correct result 3 cycles after acceptance.
